// File: rtl/reorder_commit.sv
// -----------------------------------------------------------------------------
// reorder_commit
//
// In-order reorder buffer and commit stage. Dispatch pushes entries in program
// order into a DP-deep circular buffer. The head entry retires (at most one per
// cycle) once its completion condition holds:
//   - branches wait for the branch unit to resolve,
//   - stores and rd==x0 non-branches retire immediately,
//   - everything else (including CSR ops) waits on its physical register's
//     written flag in wbLog_qout.
// A mispredicted branch retiring discards every younger entry and forces a
// single FLUSH cycle during which nothing is accepted or committed.
//
// Entry layout (MSB..LSB): {pc[63:0], rd0_reName[5+RB-1:0], isBranch, isSu, isCsr}
//   rd0_reName = {arch[4:0], copy[RB-1:0]}
//
// Ports:
//   CLK, RSTn           clock, asynchronous active-low reset
//   reOrder_fifo_push   dispatch write strobe
//   dispat_info         entry to write
//   reOrder_fifo_full   no free entry, or FLUSH state
//   reOrder_fifo_empty  buffer holds no entries
//   wbLog_qout          written flag per physical register (arch*RP + copy)
//   bru_res_vaild       oldest branch resolved
//   bru_mispredict      resolved branch was mispredicted
//   commit_vaild        head retires this cycle
//   commit_rd0          head rd0_reName (0 while empty)
//   commit_rd0_vaild    retiring head writes a nonzero architectural rd
//   commit_pc           head pc (0 while empty)
//   commit_su           retiring head is a store
//   commit_abort        retiring branch mispredicted
//   instret_cnt         retired instruction count
//
// Optional feature macro: RIFT_RETIRE_CNT_EN
//   defined   -> instret_cnt is a free-running 64-bit retire counter
//   undefined -> instret_cnt is tied to 0
// -----------------------------------------------------------------------------
module reorder_commit #(
  parameter int DP = 16,
  parameter int RB = 4
) (
  input  logic                         CLK,
  input  logic                         RSTn,
  input  logic                         reOrder_fifo_push,
  input  logic [64+5+RB+3-1:0]         dispat_info,
  output logic                         reOrder_fifo_full,
  output logic                         reOrder_fifo_empty,
  input  logic [32*(2**RB)-1:0]        wbLog_qout,
  input  logic                         bru_res_vaild,
  input  logic                         bru_mispredict,
  output logic                         commit_vaild,
  output logic [5+RB-1:0]              commit_rd0,
  output logic                         commit_rd0_vaild,
  output logic [63:0]                  commit_pc,
  output logic                         commit_su,
  output logic                         commit_abort,
  output logic [63:0]                  instret_cnt
);

  localparam int AW = $clog2(DP);
  localparam int EW = 64 + 5 + RB + 3;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t state, next_state;

  logic [EW-1:0] mem [DP];
  logic [AW:0]   rd_ptr, wr_ptr;

  logic          ptr_full;
  logic          push_ok;

  logic [EW-1:0] head;
  logic [63:0]   head_pc;
  logic [5+RB-1:0] head_rd0;
  logic [4:0]    head_arch;
  logic          head_br, head_su, head_csr;
  logic          wb_done;
  logic          head_done;

  // Full/empty come only from the registered pointers (plus state), so there
  // is no combinational path from push or commit back into them.
  assign ptr_full           = (wr_ptr[AW] != rd_ptr[AW]) &&
                              (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign reOrder_fifo_empty = (wr_ptr == rd_ptr);
  assign reOrder_fifo_full  = ptr_full | (state == FLUSH);
  assign push_ok            = reOrder_fifo_push & ~reOrder_fifo_full;

  // Head decode
  assign head = mem[rd_ptr[AW-1:0]];
  assign {head_pc, head_rd0, head_br, head_su, head_csr} = head;
  assign head_arch = head_rd0[5+RB-1:RB];

  // rd0_reName is already {arch, copy}, i.e. arch*RP + copy.
  assign wb_done = wbLog_qout[head_rd0];

  // Completion condition; CSR ops wait on writeback just like ordinary ops.
  always_comb begin
    head_done = 1'b0;
    if (head_br)
      head_done = bru_res_vaild;
    else if (head_su)
      head_done = 1'b1;
    else if (head_arch == 5'd0)
      head_done = 1'b1;
    else if (head_csr)
      head_done = wb_done;
    else
      head_done = wb_done;
  end

  assign commit_vaild     = ~reOrder_fifo_empty & (state == RUN) & head_done;
  assign commit_rd0_vaild = commit_vaild & ~head_br & ~head_su & (head_arch != 5'd0);
  assign commit_su        = commit_vaild & head_su;
  assign commit_abort     = commit_vaild & head_br & bru_mispredict;

  // Stale storage is hidden while the buffer is empty.
  assign commit_rd0 = reOrder_fifo_empty ? '0 : head_rd0;
  assign commit_pc  = reOrder_fifo_empty ? '0 : head_pc;

  // State register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)
      state <= RUN;
    else
      state <= next_state;
  end

  // Next state: an abort buys exactly one FLUSH cycle.
  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (commit_abort) next_state = FLUSH;
      FLUSH:   next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  // Pointers: abort discards everything younger, including a same-cycle push.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (commit_abort) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (commit_vaild)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage is not reset; the empty mask covers stale contents.
  always_ff @(posedge CLK) begin
    if (push_ok)
      mem[wr_ptr[AW-1:0]] <= dispat_info;
  end

`ifdef RIFT_RETIRE_CNT_EN
  logic [63:0] instret_q;

  // Retire counter survives aborts and wraps naturally.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)
      instret_q <= '0;
    else if (commit_vaild)
      instret_q <= instret_q + 64'd1;
  end

  assign instret_cnt = instret_q;
`else
  assign instret_cnt = '0;
`endif

endmodule
